// File: rtl/multi_mode_counter_if.sv
// rtl/multi_mode_counter_if.sv - control/status bundle for multi_mode_counter (MULTI_MODE_COUNTER_CMP_EN adds compare)
interface multi_mode_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             udf;
`ifdef MULTI_MODE_COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp_val;
  logic             match;

  modport master (
    output en, up_dn, clr, ld, d, sat, cmp_val,
    input  q, tc, ovf, udf, match
  );

  modport slave (
    input  en, up_dn, clr, ld, d, sat, cmp_val,
    output q, tc, ovf, udf, match
  );
`else
  modport master (
    output en, up_dn, clr, ld, d, sat,
    input  q, tc, ovf, udf
  );

  modport slave (
    input  en, up_dn, clr, ld, d, sat,
    output q, tc, ovf, udf
  );
`endif
endinterface

// File: rtl/multi_mode_counter.sv
// rtl/multi_mode_counter.sv - prescaled up/down counter with wrap/saturate, tc pulse, sticky flags
// Optional compare/match output enabled by defining MULTI_MODE_COUNTER_CMP_EN.
module multi_mode_counter #(
  parameter int          WIDTH    = 8,
  parameter int unsigned INIT_VAL = 0,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int          PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  multi_mode_counter_if.slave  bus
);

  localparam int unsigned    INIT_CL  = (INIT_VAL > MAX_VAL) ? MAX_VAL : INIT_VAL;
  localparam logic [WIDTH-1:0] MAX_Q  = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_Q = INIT_CL[WIDTH-1:0];
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // With PRESCALE=1 the prescaler is pinned at 0 == PRE_LAST, so step follows en.
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q,   q_d;
  logic             tc_q,  tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             step;
  logic             moved;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q   <= INIT_Q;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      pre_q <= '0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      pre_q <= pre_d;
    end
  end

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    udf_d = udf_q;
    pre_d = pre_q;
    step  = 1'b0;
    moved = 1'b0;

    if (bus.clr) begin
      q_d   = INIT_Q;
      ovf_d = 1'b0;
      udf_d = 1'b0;
      pre_d = '0;
    end else if (bus.ld) begin
      q_d   = (bus.d > MAX_Q) ? MAX_Q : bus.d;
      pre_d = '0;
      moved = 1'b1;
    end else if (bus.en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (step) begin
      moved = 1'b1;
      if (bus.up_dn) begin
        if (q_q >= MAX_Q) begin
          q_d   = bus.sat ? MAX_Q : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d   = bus.sat ? '0 : MAX_Q;
          tc_d  = 1'b1;
          udf_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.q   = q_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;

`ifdef MULTI_MODE_COUNTER_CMP_EN
  logic match_q, match_d;

  // Pulse only on arrival at cmp_val, not while q sits on it.
  always_comb begin
    match_d = moved && (q_d == bus.cmp_val) && (q_d != q_q);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign bus.match = match_q;
`endif

endmodule
